pingpong_mem_ctrl: RTL and testbench
====================================

# pingpong_mem_ctrl

Parametrised double-buffered (ping-pong) SRAM controller between a producer stage and a consumer stage. It maps NPORT logical write ports onto the current write bank and NPORT logical read ports onto the current read bank. Each logical word is striped across DATA_W/MACRO_W dual-port SRAM macros per bank. It owns the bank-swap handshake and read-data return, replacing the software-driven bank select used so far.

## Interface
- DATA_W, 128: logical word width; must be a multiple of MACRO_W
- MACRO_W, 64: width of one SRAM macro; M = DATA_W/MACRO_W macros per bank
- ADDR_W, 8: word address width; bank depth 2^ADDR_W
- NPORT, 2: logical read ports and logical write ports; 1 or 2 (port p uses macro port A for p=0, B for p=1)
- clk  in  1  system clock; SRAM CLKA/CLKB are driven by clk at integration
- rst_n  in  1  synchronous reset, active low
- wr_en  in  NPORT  write request per port
- waddr  in  NPORT*ADDR_W  write addresses, port p at [p*ADDR_W +: ADDR_W]
- wdata  in  NPORT*DATA_W  write data, packed the same way
- wr_last  in  1  producer has finished filling the write bank
- rd_en  in  NPORT  read request per port
- raddr  in  NPORT*ADDR_W  read addresses
- rd_done  in  1  consumer has released the read bank
- rdata  out  NPORT*DATA_W  read data, valid when rd_valid[p] is high
- rd_valid  out  NPORT  read-return strobe
- read_sel  out  1  bank currently readable; the other bank is writable
- rbank_valid  out  1  read bank holds an unreleased frame
- wbank_full  out  1  write bank is closed and awaiting swap
- swap_pulse  out  1  one-cycle strobe on the cycle after a swap
- wr_drop  out  1  a write was discarded (bank full or port collision)
- swap_count  out  16  number of swaps since reset; wraps
- Per macro k = b*M+m (bank b, slice m), packed vectors of 2*M entries: sram_bist, sram_awt, sram_ceba, sram_cebb, sram_weba, sram_webb (1 bit each); sram_aa, sram_ab (ADDR_W); sram_da, sram_db, sram_bweba, sram_bwebb (MACRO_W) out; sram_qa, sram_qb (MACRO_W) in

## Operation
- Bank b is the read bank when b == read_sel; the other bank is the write bank. Reads never target the write bank.
- Word slice m maps to bits [m*MACRO_W +: MACRO_W]. All M macros of a bank share the same address and enables.
- Tie-offs: BIST=0, AWT=0, BWEB=all 0 (all bits enabled). CEB/WEB are active low.
- Write on port p: write-bank macros drive CEB=0, WEB=0, address and data slices. Read on port p: read-bank macros drive CEB=0, WEB=1. Unused ports drive CEB=1, WEB=1, address 0, data 0.
- Two write ports with the same address in one cycle: port 0 wins, port 1 is suppressed, and wr_drop pulses.
- Swap flags are registers:
  - wfull is set by wr_last.
  - rfree is set by rd_done.
  - When wfull && rfree are both registered high at a posedge: read_sel toggles, wfull clears, rfree clears, swap_count increments, and swap_pulse is high for the following cycle.
- Writes while wfull=1 are dropped (CEB=1) and wr_drop pulses. Reads are always serviced.
- wbank_full = wfull; rbank_valid = !rfree.

## Timing
- Reset values: read_sel=0, wfull=0, rfree=1, rd_valid=0, rdata=0, swap_pulse=0, wr_drop=0, swap_count=0. While rst_n=0, all CEB outputs are forced to 1.
- SRAM control outputs are combinational from the request inputs, and the SRAM samples them at the next posedge.
- Read latency is one cycle. rd_en[p] high at edge N gives rd_valid[p] high at N+1, with rdata taken from the bank latched at edge N. A read issued in the swap cycle therefore returns old-bank data.
- Requests in the swap cycle use the pre-swap mapping.
- The earliest swap is the edge after both flags are set. A wr_last and rd_done arriving in the same cycle cause a swap one cycle later.
- A wr_en issued together with wr_last is performed.
- An rd_done issued while rfree=1 has no effect.
- A reset mid-frame discards all flags and in-flight rd_valid; SRAM contents are untouched.

## Test plan
- Reset, then write 0xAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DDDD_DDDD to 0x1A (port 0) and 0x1111_..._8888 to 0x1B (port 1) -> only bank 1 macros see CEB=0/WEB=0, with upper and lower 64-bit slices split correctly.
- wr_last, then rd_done -> swap on the following edge: read_sel=1, swap_pulse for one cycle, swap_count=1. Reads of 0x1A/0x1B then return the same two words with rd_valid one cycle after rd_en.
- wr_en on both ports to 0x2A in one cycle -> only the port 0 data is stored, and wr_drop=1 for one cycle.
- Assert wr_last, hold rfree=0, keep writing -> writes dropped, wr_drop high each cycle, read_sel unchanged.
- Issue rd_en at the swap edge -> data returned from the old bank. The next read returns new-bank data.
- Assert rst_n=0 mid-read with rd_en held -> rd_valid=0 next cycle, all CEB=1, read_sel=0.

Source files
------------

// File: rtl/pingpong_mem_ctrl.sv
// pingpong_mem_ctrl: double-buffered SRAM controller between a producer and a consumer.
// Two banks of M = DATA_W/MACRO_W dual-port macros. One bank is read while the other is written.
// Logical port p drives macro port A (p=0) or macro port B (p=1).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   wr_en/waddr/wdata/wr_last       producer side: writes and end-of-frame
//   rd_en/raddr/rd_done             consumer side: reads and bank release
//   rdata/rd_valid                  registered read return
//   read_sel/rbank_valid/wbank_full bank state
//   swap_pulse/wr_drop/swap_count   event strobes and swap counter
//   sram_*                          per-macro pins, macro k = bank*M + slice
module pingpong_mem_ctrl #(
   parameter int unsigned DATA_W  = 128,
   parameter int unsigned MACRO_W = 64,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned NPORT   = 2
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [NPORT-1:0]                        wr_en,
   input  logic [NPORT*ADDR_W-1:0]                 waddr,
   input  logic [NPORT*DATA_W-1:0]                 wdata,
   input  logic                                    wr_last,
   input  logic [NPORT-1:0]                        rd_en,
   input  logic [NPORT*ADDR_W-1:0]                 raddr,
   input  logic                                    rd_done,
   output logic [NPORT*DATA_W-1:0]                 rdata,
   output logic [NPORT-1:0]                        rd_valid,
   output logic                                    read_sel,
   output logic                                    rbank_valid,
   output logic                                    wbank_full,
   output logic                                    swap_pulse,
   output logic                                    wr_drop,
   output logic [15:0]                             swap_count,
   output logic [2*(DATA_W/MACRO_W)-1:0]           sram_bist,
   output logic [2*(DATA_W/MACRO_W)-1:0]           sram_awt,
   output logic [2*(DATA_W/MACRO_W)-1:0]           sram_ceba,
   output logic [2*(DATA_W/MACRO_W)-1:0]           sram_cebb,
   output logic [2*(DATA_W/MACRO_W)-1:0]           sram_weba,
   output logic [2*(DATA_W/MACRO_W)-1:0]           sram_webb,
   output logic [2*(DATA_W/MACRO_W)*ADDR_W-1:0]    sram_aa,
   output logic [2*(DATA_W/MACRO_W)*ADDR_W-1:0]    sram_ab,
   output logic [2*(DATA_W/MACRO_W)*MACRO_W-1:0]   sram_da,
   output logic [2*(DATA_W/MACRO_W)*MACRO_W-1:0]   sram_db,
   output logic [2*(DATA_W/MACRO_W)*MACRO_W-1:0]   sram_bweba,
   output logic [2*(DATA_W/MACRO_W)*MACRO_W-1:0]   sram_bwebb,
   input  logic [2*(DATA_W/MACRO_W)*MACRO_W-1:0]   sram_qa,
   input  logic [2*(DATA_W/MACRO_W)*MACRO_W-1:0]   sram_qb
);

   localparam int unsigned M    = DATA_W / MACRO_W;
   localparam int unsigned NMAC = 2 * M;

   // state registers
   logic              read_sel_q;
   logic              wfull_q;
   logic              rfree_q;
   logic              rd_bank_q;
   logic [1:0]        rd_pend_q;
   logic [1:0]        rd_valid_q;
   logic [DATA_W-1:0] rdata_q [2];
   logic              swap_pulse_q;
   logic              wr_drop_q;
   logic [15:0]       swap_cnt_q;

   // requests widened to two ports; an absent port never requests
   logic [1:0]        wr_req;
   logic [1:0]        rd_req;
   logic [ADDR_W-1:0] wa [2];
   logic [ADDR_W-1:0] ra [2];
   logic [DATA_W-1:0] wd [2];
   logic [1:0]        wr_ok;
   logic              collision_c;
   logic              swap_c;
   logic [DATA_W-1:0] rq_c [2];

   for (genvar p = 0; p < 2; p++) begin : g_port
      if (p < NPORT) begin : g_used
         assign wr_req[p] = wr_en[p];
         assign rd_req[p] = rd_en[p];
         assign wa[p]     = waddr[p*ADDR_W +: ADDR_W];
         assign ra[p]     = raddr[p*ADDR_W +: ADDR_W];
         assign wd[p]     = wdata[p*DATA_W +: DATA_W];
         assign rdata[p*DATA_W +: DATA_W] = rdata_q[p];
      end else begin : g_unused
         assign wr_req[p] = 1'b0;
         assign rd_req[p] = 1'b0;
         assign wa[p]     = '0;
         assign ra[p]     = '0;
         assign wd[p]     = '0;
      end
   end

   // same-address writes: port 0 wins; full write bank blocks everything
   assign collision_c = wr_req[0] & wr_req[1] & (wa[0] == wa[1]);
   assign wr_ok[0]    = wr_req[0] & ~wfull_q;
   assign wr_ok[1]    = wr_req[1] & ~wfull_q & ~collision_c;
   assign swap_c      = wfull_q & rfree_q;

   // fixed macro tie-offs
   assign sram_bist  = '0;
   assign sram_awt   = '0;
   assign sram_bweba = '0;
   assign sram_bwebb = '0;

   // per-macro pin mapping from the request inputs and the current bank select
   for (genvar k = 0; k < NMAC; k++) begin : g_mac
      localparam int unsigned BANK  = k / M;
      localparam int unsigned SLICE = k % M;
      logic is_r, wa_sel, ra_sel, wb_sel, rb_sel;

      assign is_r   = (read_sel_q == 1'(BANK));
      assign wa_sel = ~is_r & wr_ok[0];
      assign ra_sel =  is_r & rd_req[0];
      assign wb_sel = ~is_r & wr_ok[1];
      assign rb_sel =  is_r & rd_req[1];

      assign sram_ceba[k] = ~(rst_n & (wa_sel | ra_sel));
      assign sram_weba[k] = ~(rst_n & wa_sel);
      assign sram_aa[k*ADDR_W +: ADDR_W]   = wa_sel ? wa[0] : (ra_sel ? ra[0] : '0);
      assign sram_da[k*MACRO_W +: MACRO_W] = wa_sel ? wd[0][SLICE*MACRO_W +: MACRO_W] : '0;

      assign sram_cebb[k] = ~(rst_n & (wb_sel | rb_sel));
      assign sram_webb[k] = ~(rst_n & wb_sel);
      assign sram_ab[k*ADDR_W +: ADDR_W]   = wb_sel ? wa[1] : (rb_sel ? ra[1] : '0);
      assign sram_db[k*MACRO_W +: MACRO_W] = wb_sel ? wd[1][SLICE*MACRO_W +: MACRO_W] : '0;
   end

   // gather macro Q slices of the bank that was read at issue time
   always_comb begin
      int base;
      rq_c[0] = '0;
      rq_c[1] = '0;
      base    = 0;
      for (int m = 0; m < int'(M); m++) begin
         base = (int'(rd_bank_q) * int'(M) + m) * int'(MACRO_W);
         rq_c[0][m*MACRO_W +: MACRO_W] = sram_qa[base +: MACRO_W];
         rq_c[1][m*MACRO_W +: MACRO_W] = sram_qb[base +: MACRO_W];
      end
   end

   // swap flags, read pipeline and event strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         read_sel_q   <= 1'b0;
         wfull_q      <= 1'b0;
         rfree_q      <= 1'b1;
         rd_bank_q    <= 1'b0;
         rd_pend_q    <= '0;
         rd_valid_q   <= '0;
         rdata_q[0]   <= '0;
         rdata_q[1]   <= '0;
         swap_pulse_q <= 1'b0;
         wr_drop_q    <= 1'b0;
         swap_cnt_q   <= '0;
      end else begin
         if (swap_c) begin
            // wr_last/rd_done seen in the swap cycle refer to the pre-swap banks
            read_sel_q   <= ~read_sel_q;
            wfull_q      <= 1'b0;
            rfree_q      <= 1'b0;
            swap_cnt_q   <= swap_cnt_q + 16'd1;
            swap_pulse_q <= 1'b1;
         end else begin
            wfull_q      <= wfull_q | wr_last;
            rfree_q      <= rfree_q | rd_done;
            swap_pulse_q <= 1'b0;
         end
         wr_drop_q  <= (wfull_q & (|wr_req)) | (~wfull_q & collision_c);
         rd_pend_q  <= rd_req;
         rd_bank_q  <= read_sel_q;
         rd_valid_q <= rd_pend_q;
         if (rd_pend_q[0]) rdata_q[0] <= rq_c[0];
         if (rd_pend_q[1]) rdata_q[1] <= rq_c[1];
      end
   end

   assign rd_valid    = rd_valid_q[NPORT-1:0];
   assign read_sel    = read_sel_q;
   assign wbank_full  = wfull_q;
   assign rbank_valid = ~rfree_q;
   assign swap_pulse  = swap_pulse_q;
   assign wr_drop     = wr_drop_q;
   assign swap_count  = swap_cnt_q;

endmodule

// File: tb/tb_pingpong_mem_ctrl.sv
// Directed bench for pingpong_mem_ctrl with a behavioural dual-port SRAM model per macro.
module tb_pingpong_mem_ctrl;

   localparam int unsigned DATA_W  = 128;
   localparam int unsigned MACRO_W = 64;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned NPORT   = 2;
   localparam int unsigned NMAC    = 4;

   localparam logic [127:0] W0 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
   localparam logic [127:0] W1 = 128'h11112222_33334444_55556666_77778888;
   localparam logic [127:0] D0 = 128'h0D0D0D0D_00000000_F0F0F0F0_00000001;
   localparam logic [127:0] D1 = 128'h1D1D1D1D_00000000_F1F1F1F1_00000002;
   localparam logic [127:0] D2 = 128'h2D2D2D2D_00000000_F2F2F2F2_00000003;
   localparam logic [127:0] D3 = 128'h3D3D3D3D_00000000_F3F3F3F3_00000004;
   localparam logic [127:0] D4 = 128'h4D4D4D4D_00000000_F4F4F4F4_00000005;

   logic clk = 1'b0;
   logic rst_n;
   logic [NPORT-1:0]         wr_en, rd_en, rd_valid;
   logic [NPORT*ADDR_W-1:0]  waddr, raddr;
   logic [NPORT*DATA_W-1:0]  wdata, rdata;
   logic wr_last, rd_done, read_sel, rbank_valid, wbank_full, swap_pulse, wr_drop;
   logic [15:0] swap_count;
   logic [NMAC-1:0] sram_bist, sram_awt, sram_ceba, sram_cebb, sram_weba, sram_webb;
   logic [NMAC*ADDR_W-1:0]  sram_aa, sram_ab;
   logic [NMAC*MACRO_W-1:0] sram_da, sram_db, sram_bweba, sram_bwebb, sram_qa, sram_qb;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   pingpong_mem_ctrl #(.DATA_W(DATA_W), .MACRO_W(MACRO_W), .ADDR_W(ADDR_W), .NPORT(NPORT)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .wr_last(wr_last),
      .rd_en(rd_en), .raddr(raddr), .rd_done(rd_done),
      .rdata(rdata), .rd_valid(rd_valid), .read_sel(read_sel),
      .rbank_valid(rbank_valid), .wbank_full(wbank_full), .swap_pulse(swap_pulse),
      .wr_drop(wr_drop), .swap_count(swap_count),
      .sram_bist(sram_bist), .sram_awt(sram_awt),
      .sram_ceba(sram_ceba), .sram_cebb(sram_cebb),
      .sram_weba(sram_weba), .sram_webb(sram_webb),
      .sram_aa(sram_aa), .sram_ab(sram_ab),
      .sram_da(sram_da), .sram_db(sram_db),
      .sram_bweba(sram_bweba), .sram_bwebb(sram_bwebb),
      .sram_qa(sram_qa), .sram_qb(sram_qb)
   );

   // behavioural dual-port macros, one-cycle registered read
   for (genvar k = 0; k < NMAC; k++) begin : g_sram
      logic [MACRO_W-1:0] mem [256];
      logic [MACRO_W-1:0] qa_r, qb_r;
      always @(posedge clk) begin
         if (!sram_ceba[k]) begin
            if (!sram_weba[k]) mem[sram_aa[k*ADDR_W +: ADDR_W]] <= sram_da[k*MACRO_W +: MACRO_W];
            else               qa_r <= mem[sram_aa[k*ADDR_W +: ADDR_W]];
         end
         if (!sram_cebb[k]) begin
            if (!sram_webb[k]) mem[sram_ab[k*ADDR_W +: ADDR_W]] <= sram_db[k*MACRO_W +: MACRO_W];
            else               qb_r <= mem[sram_ab[k*ADDR_W +: ADDR_W]];
         end
      end
      assign sram_qa[k*MACRO_W +: MACRO_W] = qa_r;
      assign sram_qb[k*MACRO_W +: MACRO_W] = qb_r;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rd_en = 2'b11; raddr = {8'h05, 8'h04};
      tick(); tick(); tick();
      chk_cnt++; if ({sram_ceba, sram_cebb} !== 8'hFF) $display("FAIL reset_ceb got=%h exp=ff", {sram_ceba, sram_cebb}); else pass_cnt++;
      chk_cnt++; if (read_sel !== 1'b0) $display("FAIL reset_read_sel got=%b exp=0", read_sel); else pass_cnt++;
      chk_cnt++; if (swap_count !== 16'd0) $display("FAIL reset_swap_count got=%0d exp=0", swap_count); else pass_cnt++;
      chk_cnt++; if (rd_valid !== 2'b00) $display("FAIL reset_rd_valid got=%b exp=00", rd_valid); else pass_cnt++;
      chk_cnt++; if (rdata !== '0) $display("FAIL reset_rdata got=%h exp=0", rdata); else pass_cnt++;
      chk_cnt++; if ({wbank_full, rbank_valid, swap_pulse, wr_drop} !== 4'b0000)
         $display("FAIL reset_flags got=%b exp=0000", {wbank_full, rbank_valid, swap_pulse, wr_drop}); else pass_cnt++;
      rd_en = 2'b00; rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write();
      wr_en = 2'b11; waddr = {8'h1B, 8'h1A}; wdata = {W1, W0};
      #1;
      chk_cnt++; if ({sram_ceba, sram_weba, sram_cebb, sram_webb} !== 16'h3333)
         $display("FAIL write_bank1_en got=%h exp=3333", {sram_ceba, sram_weba, sram_cebb, sram_webb}); else pass_cnt++;
      chk_cnt++; if ({sram_da[3*64 +: 64], sram_da[2*64 +: 64]} !== W0)
         $display("FAIL write_da_slices got=%h exp=%h", {sram_da[3*64 +: 64], sram_da[2*64 +: 64]}, W0); else pass_cnt++;
      chk_cnt++; if ({sram_db[3*64 +: 64], sram_db[2*64 +: 64]} !== W1)
         $display("FAIL write_db_slices got=%h exp=%h", {sram_db[3*64 +: 64], sram_db[2*64 +: 64]}, W1); else pass_cnt++;
      chk_cnt++; if ({sram_aa[2*8 +: 8], sram_ab[3*8 +: 8]} !== 16'h1A1B)
         $display("FAIL write_addr got=%h exp=1a1b", {sram_aa[2*8 +: 8], sram_ab[3*8 +: 8]}); else pass_cnt++;
      tick();
      wr_en = 2'b00;
      chk_cnt++; if (wr_drop !== 1'b0) $display("FAIL write_no_drop got=%b exp=0", wr_drop); else pass_cnt++;
   endtask

   task automatic test_swap();
      wr_last = 1'b1;
      tick();
      wr_last = 1'b0; rd_done = 1'b1;
      chk_cnt++; if ({wbank_full, read_sel, swap_pulse} !== 3'b100)
         $display("FAIL swap_pre got=%b exp=100", {wbank_full, read_sel, swap_pulse}); else pass_cnt++;
      tick();
      rd_done = 1'b0;
      chk_cnt++; if ({read_sel, swap_pulse, wbank_full, rbank_valid} !== 4'b1101)
         $display("FAIL swap_state got=%b exp=1101", {read_sel, swap_pulse, wbank_full, rbank_valid}); else pass_cnt++;
      chk_cnt++; if (swap_count !== 16'd1) $display("FAIL swap_count1 got=%0d exp=1", swap_count); else pass_cnt++;
      tick();
      chk_cnt++; if (swap_pulse !== 1'b0) $display("FAIL swap_pulse_len got=%b exp=0", swap_pulse); else pass_cnt++;
   endtask

   task automatic test_read_back();
      rd_en = 2'b11; raddr = {8'h1B, 8'h1A};
      #1;
      chk_cnt++; if ({sram_ceba, sram_weba, sram_cebb, sram_webb} !== 16'h3F3F)
         $display("FAIL read_en got=%h exp=3f3f", {sram_ceba, sram_weba, sram_cebb, sram_webb}); else pass_cnt++;
      tick();
      rd_en = 2'b00;
      chk_cnt++; if (rd_valid !== 2'b00) $display("FAIL read_early got=%b exp=00", rd_valid); else pass_cnt++;
      tick();
      chk_cnt++; if (rd_valid !== 2'b11) $display("FAIL read_valid got=%b exp=11", rd_valid); else pass_cnt++;
      chk_cnt++; if (rdata !== {W1, W0}) $display("FAIL read_data got=%h exp=%h", rdata, {W1, W0}); else pass_cnt++;
      tick();
      chk_cnt++; if (rd_valid !== 2'b00) $display("FAIL read_valid_len got=%b exp=00", rd_valid); else pass_cnt++;
   endtask

   task automatic test_collision();
      wr_en = 2'b11; waddr = {8'h2A, 8'h2A}; wdata = {D1, D0};
      #1;
      chk_cnt++; if ({sram_ceba, sram_cebb} !== 8'hCF)
         $display("FAIL coll_ceb got=%h exp=cf", {sram_ceba, sram_cebb}); else pass_cnt++;
      tick();
      wr_en = 2'b01; waddr = {8'h00, 8'h2C}; wdata = {128'h0, D3};
      chk_cnt++; if (wr_drop !== 1'b1) $display("FAIL coll_drop got=%b exp=1", wr_drop); else pass_cnt++;
      tick();
      wr_en = 2'b00;
      chk_cnt++; if (wr_drop !== 1'b0) $display("FAIL coll_drop_len got=%b exp=0", wr_drop); else pass_cnt++;
   endtask

   task automatic test_full_drop();
      wr_last = 1'b1; wr_en = 2'b01; waddr = {8'h00, 8'h2B}; wdata = {128'h0, D2};
      #1;
      chk_cnt++; if (sram_ceba !== 4'hC) $display("FAIL last_write_ceba got=%h exp=c", sram_ceba); else pass_cnt++;
      tick();
      wr_last = 1'b0;
      chk_cnt++; if ({wbank_full, rbank_valid, wr_drop} !== 3'b110)
         $display("FAIL full_state got=%b exp=110", {wbank_full, rbank_valid, wr_drop}); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         wr_en = 2'b11; waddr = {8'h2D, 8'h2C}; wdata = {D4, D4};
         #1;
         chk_cnt++; if ({sram_ceba, sram_cebb} !== 8'hFF)
            $display("FAIL full_ceb[%0d] got=%h exp=ff", i, {sram_ceba, sram_cebb}); else pass_cnt++;
         tick();
         chk_cnt++; if ({wr_drop, read_sel} !== 2'b11)
            $display("FAIL full_drop[%0d] got=%b exp=11", i, {wr_drop, read_sel}); else pass_cnt++;
      end
      wr_en = 2'b00;
      tick();
      chk_cnt++; if (wr_drop !== 1'b0) $display("FAIL full_drop_end got=%b exp=0", wr_drop); else pass_cnt++;
   endtask

   task automatic test_swap_read();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      chk_cnt++; if (rbank_valid !== 1'b0) $display("FAIL release got=%b exp=0", rbank_valid); else pass_cnt++;
      rd_en = 2'b01; raddr = {8'h00, 8'h1A};
      #1;
      chk_cnt++; if (sram_ceba !== 4'h3) $display("FAIL swapcyc_map got=%h exp=3", sram_ceba); else pass_cnt++;
      tick();
      chk_cnt++; if ({read_sel, swap_pulse} !== 2'b01 || swap_count !== 16'd2)
         $display("FAIL swap2 got=%b/%0d exp=01/2", {read_sel, swap_pulse}, swap_count); else pass_cnt++;
      rd_en = 2'b11; raddr = {8'h2B, 8'h2A};
      tick();
      chk_cnt++; if (rd_valid !== 2'b01 || rdata[127:0] !== W0)
         $display("FAIL oldbank_read got=%b/%h exp=01/%h", rd_valid, rdata[127:0], W0); else pass_cnt++;
      rd_en = 2'b01; raddr = {8'h00, 8'h2C};
      tick();
      rd_en = 2'b00;
      chk_cnt++; if (rd_valid !== 2'b11 || rdata !== {D2, D0})
         $display("FAIL newbank_read got=%b/%h exp=11/%h", rd_valid, rdata, {D2, D0}); else pass_cnt++;
      tick();
      chk_cnt++; if (rd_valid !== 2'b01 || rdata[127:0] !== D3)
         $display("FAIL dropped_not_stored got=%b/%h exp=01/%h", rd_valid, rdata[127:0], D3); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      wr_last = 1'b1;
      tick();
      wr_last = 1'b0; rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      tick();
      chk_cnt++; if (read_sel !== 1'b1 || swap_count !== 16'd3)
         $display("FAIL swap3 got=%b/%0d exp=1/3", read_sel, swap_count); else pass_cnt++;
      rd_en = 2'b11; raddr = {8'h1B, 8'h1A};
      tick();
      rst_n = 1'b0;
      #1;
      chk_cnt++; if ({sram_ceba, sram_cebb} !== 8'hFF)
         $display("FAIL midrst_ceb got=%h exp=ff", {sram_ceba, sram_cebb}); else pass_cnt++;
      tick();
      chk_cnt++; if (rd_valid !== 2'b00) $display("FAIL midrst_rd_valid got=%b exp=00", rd_valid); else pass_cnt++;
      chk_cnt++; if ({read_sel, wbank_full} !== 2'b00 || swap_count !== 16'd0)
         $display("FAIL midrst_state got=%b/%0d exp=00/0", {read_sel, wbank_full}, swap_count); else pass_cnt++;
      rst_n = 1'b1; rd_en = 2'b00;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; wr_en = '0; waddr = '0; wdata = '0; wr_last = 1'b0;
      rd_en = '0; raddr = '0; rd_done = 1'b0;
      test_reset();
      test_write();
      test_swap();
      test_read_back();
      test_collision();
      test_full_drop();
      test_swap_read();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
